// File: rtl/qoa_spi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | qoa_spi_pkg : shared types and constants for the QOA SPI host              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package qoa_spi_pkg;

  localparam int FRAME_BITS = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRE_HI   = 3'd1,
    ST_PRE_LO   = 3'd2,
    ST_SETUP    = 3'd3,
    ST_SHIFT_HI = 3'd4,
    ST_SHIFT_LO = 3'd5,
    ST_HOLD     = 3'd6,
    ST_GAP      = 3'd7
  } state_e;

  // Cycles from the cycle start is accepted to the cycle done is high.
  function automatic int frame_latency(input int clk_div, input int cs_setup,
                                       input int cs_hold, input int cs_gap,
                                       input int preamble);
    return 1 + preamble * 2 * clk_div + cs_setup + 2 * FRAME_BITS * clk_div
           + cs_hold + cs_gap;
  endfunction

endpackage
`default_nettype wire

// File: rtl/qoa_spi_tick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | qoa_spi_tick : SCLK half-period divider, pulses phase_end each half-period |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module qoa_spi_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic restart,
  output logic phase_end
);

  localparam int               CNT_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign phase_end = en && (cnt_q == CNT_LAST);

  // Restart is raised in the last cycle of the old state so the new state
  // begins at count zero.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (!en || restart || phase_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/qoa_spi_host.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | qoa_spi_host : SPI mode-0 master, fixed 16-bit full-duplex frames          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module qoa_spi_host
  import qoa_spi_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 4,
  parameter int PREAMBLE = 1
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] tx_word,
  output logic                  busy,
  output logic                  done,
  output logic [FRAME_BITS-1:0] rx_word,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  cs_n,
  input  logic                  miso
);

  localparam int               BIT_W      = $clog2(FRAME_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(FRAME_BITS - 1);
  localparam logic [15:0]      SETUP_LAST = 16'(CS_SETUP - 1);
  localparam logic [15:0]      HOLD_LAST  = 16'(CS_HOLD - 1);
  localparam logic [15:0]      GAP_LAST   = 16'(CS_GAP - 1);

  state_e                  state_q, state_d;
  logic [15:0]             wait_q, wait_d;
  logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0]   tx_sr_q, tx_sr_d;
  logic [FRAME_BITS-1:0]   rx_sr_q, rx_sr_d;
  logic [FRAME_BITS-1:0]   rx_word_q, rx_word_d;
  logic                    sclk_q, sclk_d;
  logic                    mosi_q, mosi_d;
  logic                    cs_n_q, cs_n_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    tick_en;
  logic                    tick_restart;
  logic                    phase_end;

  assign tick_en      = state_q inside {ST_PRE_HI, ST_PRE_LO, ST_SHIFT_HI, ST_SHIFT_LO};
  assign tick_restart = (state_d != state_q);

  qoa_spi_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk       (sys_clk),
    .rst_n     (sys_rst_n),
    .en        (tick_en),
    .restart   (tick_restart),
    .phase_end (phase_end)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (start) state_d = (PREAMBLE != 0) ? ST_PRE_HI : ST_SETUP;
      ST_PRE_HI:   if (phase_end) state_d = ST_PRE_LO;
      ST_PRE_LO:   if (phase_end) state_d = ST_SETUP;
      ST_SETUP:    if (wait_q == SETUP_LAST) state_d = ST_SHIFT_HI;
      ST_SHIFT_HI: if (phase_end) state_d = ST_SHIFT_LO;
      ST_SHIFT_LO: if (phase_end) state_d = (bit_cnt_q == LAST_BIT) ? ST_HOLD : ST_SHIFT_HI;
      ST_HOLD:     if (wait_q == HOLD_LAST) state_d = ST_GAP;
      ST_GAP:      if (wait_q == GAP_LAST) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Output registers are loaded from the next state, so every pin lines up
  // exactly with the state it belongs to.
  always_comb begin
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    bit_cnt_d = bit_cnt_q;
    rx_word_d = rx_word_q;
    wait_d    = '0;

    if ((state_d == state_q) && (state_q inside {ST_SETUP, ST_HOLD, ST_GAP})) begin
      wait_d = wait_q + 16'd1;
    end

    if ((state_q == ST_IDLE) && start) begin
      tx_sr_d   = tx_word;
      bit_cnt_d = '0;
    end

    // MISO is sampled in the last high cycle; MOSI advances as SCLK falls,
    // except after the final bit so bit 0 stays on the line through HOLD.
    if ((state_q == ST_SHIFT_HI) && phase_end) begin
      rx_sr_d = {rx_sr_q[FRAME_BITS-2:0], miso};
      if (bit_cnt_q != LAST_BIT) begin
        tx_sr_d = {tx_sr_q[FRAME_BITS-2:0], 1'b0};
      end
    end

    if ((state_q == ST_SHIFT_LO) && phase_end) begin
      bit_cnt_d = bit_cnt_q + BIT_W'(1);
    end

    sclk_d = (state_d == ST_PRE_HI) || (state_d == ST_SHIFT_HI);
    cs_n_d = !(state_d inside {ST_SETUP, ST_SHIFT_HI, ST_SHIFT_LO, ST_HOLD});
    mosi_d = cs_n_d ? 1'b0 : tx_sr_d[FRAME_BITS-1];
    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_GAP) && (state_d == ST_IDLE);

    if (done_d) begin
      rx_word_d = rx_sr_q;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wait_q    <= '0;
      bit_cnt_q <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_word_q <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      bit_cnt_q <= bit_cnt_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_word_q <= rx_word_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_word = rx_word_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign cs_n    = cs_n_q;

endmodule
`default_nettype wire

// File: tb/tb_qoa_spi_host.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_qoa_spi_host : bench for qoa_spi_host with a behavioural SPI slave      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_qoa_spi_host;
  import qoa_spi_pkg::*;

  localparam int CLK_DIV  = 4;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int CS_GAP   = 4;
  localparam int PREAMBLE = 1;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] tx_word = 16'h0000;
  logic        busy, done, sclk, mosi, cs_n, miso;
  logic [15:0] rx_word;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int lat     = 0;

  // Slave model: MSB launched by the CS-high preamble fall, later bits on
  // each SCLK fall with CS low; MOSI captured on SCLK rise with CS low.
  logic [15:0] slave_resp = 16'h0000;
  logic        loop_en    = 1'b0;
  logic        miso_s     = 1'b0;
  int          slave_idx  = 15;
  logic [15:0] cap_word   = 16'h0000;
  int          rise_hi    = 0;
  int          rise_lo    = 0;
  int          done_cnt   = 0;

  qoa_spi_host #(
    .CLK_DIV  (CLK_DIV),
    .CS_SETUP (CS_SETUP),
    .CS_HOLD  (CS_HOLD),
    .CS_GAP   (CS_GAP),
    .PREAMBLE (PREAMBLE)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (start),
    .tx_word   (tx_word),
    .busy      (busy),
    .done      (done),
    .rx_word   (rx_word),
    .sclk      (sclk),
    .mosi      (mosi),
    .cs_n      (cs_n),
    .miso      (miso)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc++;
  always @(negedge sys_clk) if (done) done_cnt++;

  assign miso = loop_en ? mosi : miso_s;

  always @(negedge sclk) begin
    #1;
    if (cs_n) begin
      slave_idx = 15;
      miso_s    = slave_resp[15];
    end else if (slave_idx > 0) begin
      slave_idx--;
      miso_s = slave_resp[slave_idx];
    end
  end

  always @(posedge sclk) begin
    if (cs_n) begin
      rise_hi++;
    end else begin
      rise_lo++;
      cap_word = {cap_word[14:0], mosi};
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one frame from a negedge with DUT idle; inject_at > 0 pulses a
  // competing start (FFFF) that many cycles into the frame.
  task automatic run_frame(input logic [15:0] tx, input logic [15:0] resp,
                           input bit loop, input int inject_at, input string tag);
    int t0, t_done, hi0, lo0, d0;
    bit seen;
    logic [15:0] exp_rx;
    exp_rx     = loop ? tx : resp;
    slave_resp = resp;
    loop_en    = loop;
    hi0 = rise_hi; lo0 = rise_lo; d0 = done_cnt;
    start = 1'b1; tx_word = tx; t0 = cyc;
    @(negedge sys_clk);
    start = 1'b0; tx_word = 16'($urandom);
    check_val({tag, "_busy"}, 32'(busy), 32'd1);
    seen = 1'b0; t_done = 0;
    for (int i = 1; i <= 2 * lat && !seen; i++) begin
      if (done) begin
        seen = 1'b1; t_done = cyc;
      end else begin
        start = (i == inject_at);
        if (start) tx_word = 16'hFFFF;
        @(negedge sys_clk);
      end
    end
    start = 1'b0;
    check_val({tag, "_done_seen"}, 32'(seen), 32'd1);
    check_val({tag, "_latency"}, 32'(t_done - t0), 32'(lat));
    check_val({tag, "_rx"}, 32'(rx_word), 32'(exp_rx));
    check_val({tag, "_slave_cap"}, 32'(cap_word), 32'(tx));
    check_val({tag, "_pre_rises"}, 32'(rise_hi - hi0), 32'(PREAMBLE));
    check_val({tag, "_cs_rises"}, 32'(rise_lo - lo0), 32'd16);
    check_val({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    @(negedge sys_clk);
    #1;
    check_val({tag, "_done_width"}, 32'(done), 32'd0);
    check_val({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, hi_run, nd, prev_t, t0, r0;
    bit seen;
    logic [15:0] tx_r, resp_r;
    lat = frame_latency(CLK_DIV, CS_SETUP, CS_HOLD, CS_GAP, PREAMBLE);

    // Reset state
    repeat (4) @(negedge sys_clk);
    check_val("rst_cs_n", 32'(cs_n), 32'd1);
    check_val("rst_sclk", 32'(sclk), 32'd0);
    check_val("rst_mosi", 32'(mosi), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_rx", 32'(rx_word), 32'd0);
    check_val("rst_sclk_edges", 32'(rise_hi + rise_lo), 32'd0);
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);

    run_frame(16'hA55A, 16'h0000, 1'b1, 0, "loop_a55a");
    @(negedge sys_clk);
    run_frame(16'h1234, 16'h8001, 1'b0, 0, "slave_8001");
    check_val("slave_byte_hi", 32'(cap_word[15:8]), 32'h12);
    check_val("slave_byte_lo", 32'(cap_word[7:0]), 32'h34);

    // Start during a frame is ignored
    @(negedge sys_clk);
    d0 = done_cnt;
    run_frame(16'hA55A, 16'h0000, 1'b1, 20, "inject");
    r0 = rise_hi + rise_lo;
    repeat (300) @(negedge sys_clk);
    check_val("inject_no_second_edges", 32'(rise_hi + rise_lo - r0), 32'd0);
    check_val("inject_idle_busy", 32'(busy), 32'd0);
    check_val("inject_single_done", 32'(done_cnt - d0), 32'd1);

    // Start held high: back-to-back frames
    loop_en = 1'b1;
    start = 1'b1; tx_word = 16'h0F0F; t0 = cyc;
    nd = 0; hi_run = 0; prev_t = t0;
    for (int i = 0; i < 4 * lat && nd < 3; i++) begin
      @(negedge sys_clk);
      if (cs_n) begin
        hi_run++;
      end else begin
        if (nd > 0 && hi_run > 0) check_val("held_cs_gap", 32'(hi_run >= CS_GAP), 32'd1);
        hi_run = 0;
      end
      if (done) begin
        nd++;
        check_val("held_period", 32'(cyc - prev_t), 32'(lat));
        check_val("held_rx", 32'(rx_word), 32'h0F0F);
        prev_t = cyc;
        if (nd == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    check_val("held_frames", 32'(nd), 32'd3);
    repeat (20) @(negedge sys_clk);
    check_val("held_stop_busy", 32'(busy), 32'd0);

    // Reset in the middle of a frame
    loop_en = 1'b0; slave_resp = 16'h5A3C;
    d0 = done_cnt; r0 = rise_lo;
    start = 1'b1; tx_word = 16'h1357;
    @(negedge sys_clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (rise_lo - r0 >= 7) seen = 1'b1;
      else @(negedge sys_clk);
    end
    check_val("midrst_reach_edge7", 32'(seen), 32'd1);
    #2 sys_rst_n = 1'b0;
    #1;
    check_val("midrst_cs_n", 32'(cs_n), 32'd1);
    check_val("midrst_sclk", 32'(sclk), 32'd0);
    check_val("midrst_busy", 32'(busy), 32'd0);
    check_val("midrst_rx", 32'(rx_word), 32'd0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (200) @(negedge sys_clk);
    check_val("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    run_frame(16'h00FF, 16'($urandom), 1'b0, 0, "post_rst");

    // Random frames against the slave model or loopback
    for (int k = 0; k < 6; k++) begin
      tx_r   = 16'($urandom);
      resp_r = 16'($urandom);
      @(negedge sys_clk);
      run_frame(tx_r, resp_r, 1'($urandom_range(0, 1)), 0, $sformatf("rnd%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
